prog_loader: RTL and testbench

Program loader on the instruction-memory side of the calculator datapath. Accepts one operation per handshake as separate fields (ALU control code, register indices, immediate), encodes it into an RV32I R-type or I-type word and appends it to an L-entry program memory. The memory's combinational read port feeds the executor's instruction fetch, which decodes the words back into register-file and ALU controls.

---
 rtl/prog_loader_pkg.sv | 34 +++
 rtl/prog_loader_encoder.sv | 42 ++++
 rtl/prog_loader.sv | 117 +++++++++++
 tb/tb_prog_loader.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared encodings and loader state for prog_loader
package prog_loader_pkg;

    // ALU control codes accepted on alu_op_i
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // RV32I opcodes
    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;

    // funct3 values
    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_SLT    = 3'b010;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;

    // funct7 values
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    // addi x0,x0,0
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FULL  = 2'd2
    } load_state_e;

endpackage

// File: rtl/prog_loader_encoder.sv
// rtl/prog_loader_encoder.sv - combinational operation-fields to RV32I word encoder
module rv_instr_encoder
    import prog_loader_pkg::*;
(
    input  logic [3:0]  alu_op_i,
    input  logic        imm_sel_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [11:0] imm_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    logic [2:0] funct3;
    logic [6:0] funct7;

    // Map the ALU code to funct3/funct7; SUB has no immediate form
    always_comb begin
        funct3    = F3_ADDSUB;
        funct7    = F7_BASE;
        illegal_o = 1'b0;
        case (alu_op_i)
            ALU_AND: funct3 = F3_AND;
            ALU_OR:  funct3 = F3_OR;
            ALU_ADD: funct3 = F3_ADDSUB;
            ALU_SUB: begin
                funct3    = F3_ADDSUB;
                funct7    = F7_SUB;
                illegal_o = imm_sel_i;
            end
            ALU_SLT: funct3 = F3_SLT;
            default: illegal_o = 1'b1;
        endcase
        if (imm_sel_i) begin
            word_o = {imm_i, rs1_i, funct3, rd_i, OPC_I};
        end else begin
            word_o = {funct7, rs2_i, rs1_i, funct3, rd_i, OPC_R};
        end
    end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - encodes operations and appends them to program memory (option: PROG_NOP_FILL_EN)
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int L  = 16,
    parameter int AW = $clog2(L)
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          clear_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [3:0]    alu_op_i,
    input  logic          imm_sel_i,
    input  logic [4:0]    rd_i,
    input  logic [4:0]    rs1_i,
    input  logic [4:0]    rs2_i,
    input  logic [11:0]   imm_i,
    output logic          err_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    input  logic [AW-1:0] rd_addr_i,
    output logic [31:0]   rd_data_o
);

    load_state_e   state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [31:0]   word_q, word_d;
    logic          err_q, err_d;
    logic          mem_we;
    logic [31:0]   mem_q [L];

    logic [31:0]   enc_word;
    logic          enc_illegal;

    rv_instr_encoder u_enc (
        .alu_op_i  (alu_op_i),
        .imm_sel_i (imm_sel_i),
        .rd_i      (rd_i),
        .rs1_i     (rs1_i),
        .rs2_i     (rs2_i),
        .imm_i     (imm_i),
        .word_o    (enc_word),
        .illegal_o (enc_illegal)
    );

    // Control state; the staged word is plain data and needs no reset
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            wptr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wptr_q  <= wptr_d;
            err_q   <= err_d;
        end
        word_q <= word_d;
    end

    // Next state: accept in IDLE, commit in WRITE, hold in FULL; clear overrides all
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        wptr_d     = wptr_q;
        word_d     = word_q;
        err_d      = 1'b0;
        mem_we     = 1'b0;
        in_ready_o = (state_q == ST_IDLE);
        if (clear_i) begin
            state_d = ST_IDLE;
            count_d = '0;
            wptr_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        if (enc_illegal) begin
                            err_d = 1'b1;
                        end else begin
                            word_d  = enc_word;
                            state_d = ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    mem_we  = 1'b1;
                    wptr_d  = wptr_q + 1'b1;
                    count_d = count_q + 1'b1;
                    state_d = (count_d == (AW+1)'(L)) ? ST_FULL : ST_IDLE;
                end
                default: state_d = ST_FULL;
            endcase
        end
    end

    // Program memory write port; contents survive reset and clear
    always_ff @(posedge clock_i) begin
        if (mem_we && !reset_i) begin
            mem_q[wptr_q] <= word_q;
        end
    end

    assign err_o   = err_q;
    assign count_o = count_q;
    assign full_o  = (state_q == ST_FULL);

`ifdef PROG_NOP_FILL_EN
    assign rd_data_o = ({1'b0, rd_addr_i} >= count_q) ? NOP_WORD : mem_q[rd_addr_i];
`else
    assign rd_data_o = mem_q[rd_addr_i];
`endif

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;

    logic        clk_i = 1'b0;
    logic        reset_i, clear_i, in_valid_i, in_ready_o;
    logic [3:0]  alu_op_i;
    logic        imm_sel_i;
    logic [4:0]  rd_i, rs1_i, rs2_i;
    logic [11:0] imm_i;
    logic        err_o, full_o;
    logic [4:0]  count_o;
    logic [3:0]  rd_addr_i;
    logic [31:0] rd_data_o;

    int checks = 0;
    int errors = 0;

    prog_loader #(.L(16)) dut (
        .clock_i    (clk_i),
        .reset_i    (reset_i),
        .clear_i    (clear_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .alu_op_i   (alu_op_i),
        .imm_sel_i  (imm_sel_i),
        .rd_i       (rd_i),
        .rs1_i      (rs1_i),
        .rs2_i      (rs2_i),
        .imm_i      (imm_i),
        .err_o      (err_o),
        .count_o    (count_o),
        .full_o     (full_o),
        .rd_addr_i  (rd_addr_i),
        .rd_data_o  (rd_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Enters and leaves at a falling edge; returns one cycle after acceptance edge
    task automatic send(input logic [3:0] op, input logic isel, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
        alu_op_i   = op;
        imm_sel_i  = isel;
        rd_i       = rd;
        rs1_i      = rs1;
        rs2_i      = rs2;
        imm_i      = imm;
        in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        rd_addr_i = addr;
        #1;
        check(tag, rd_data_o, exp);
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1; clear_i = 1'b0; in_valid_i = 1'b0;
        alu_op_i = '0; imm_sel_i = 1'b0; rd_i = '0; rs1_i = '0; rs2_i = '0; imm_i = '0;
        rd_addr_i = '0;
        @(negedge clk_i);
        step();
        reset_i = 1'b0;

        check("rst_ready", {31'd0, in_ready_o}, 32'd1);
        check("rst_err",   {31'd0, err_o},      32'd0);
        check("rst_count", {27'd0, count_o},    32'd0);
        check("rst_full",  {31'd0, full_o},     32'd0);

        // ADD x3,x1,x2
        send(4'b0010, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0);
        check("add_ready_low", {31'd0, in_ready_o}, 32'd0);
        check("add_count_pre", {27'd0, count_o},    32'd0);
        step();
        check("add_ready_back", {31'd0, in_ready_o}, 32'd1);
        check("add_count",      {27'd0, count_o},    32'd1);
        read_check("add_word", 4'd0, 32'h002081B3);

        // ADDI x1,x0,5 then SUB x4,x3,x1 from an empty memory
        do_clear();
        check("clr_count", {27'd0, count_o}, 32'd0);
        send(4'b0010, 1'b1, 5'd1, 5'd0, 5'd0, 12'd5);
        step();
        send(4'b0110, 1'b0, 5'd4, 5'd3, 5'd1, 12'd0);
        step();
        check("two_count", {27'd0, count_o}, 32'd2);
        read_check("addi_word", 4'd0, 32'h00500093);
        read_check("sub_word",  4'd1, 32'h40118233);

        // SLTI x5,x1,-1
        send(4'b0111, 1'b1, 5'd5, 5'd1, 5'd0, 12'hFFF);
        step();
        read_check("slti_word", 4'd2, 32'hFFF0A293);

        // Illegal code: err one cycle, nothing written, back-to-back allowed
        send(4'b1100, 1'b0, 5'd1, 5'd1, 5'd1, 12'd0);
        check("ill_err",   {31'd0, err_o},      32'd1);
        check("ill_ready", {31'd0, in_ready_o}, 32'd1);
        check("ill_count", {27'd0, count_o},    32'd3);
        send(4'b0110, 1'b1, 5'd1, 5'd1, 5'd0, 12'd1);
        check("subi_err", {31'd0, err_o}, 32'd1);
        step();
        check("err_drop",  {31'd0, err_o},   32'd0);
        check("ill_count2", {27'd0, count_o}, 32'd3);

        // Fill all 16 words with ADD x<i>,x0,x0
        do_clear();
        for (int i = 0; i < 16; i++) begin
            send(4'b0010, 1'b0, 5'(i), 5'd0, 5'd0, 12'd0);
            step();
        end
        check("full_flag",  {31'd0, full_o},     32'd1);
        check("full_ready", {31'd0, in_ready_o}, 32'd0);
        check("full_count", {27'd0, count_o},    32'd16);
        read_check("full_last", 4'd15, 32'h00000033 | (32'd15 << 7));
        in_valid_i = 1'b1;
        step(); step(); step();
        in_valid_i = 1'b0;
        check("full_hold", {27'd0, count_o}, 32'd16);
        do_clear();
        check("full_clr_count", {27'd0, count_o},    32'd0);
        check("full_clr_ready", {31'd0, in_ready_o}, 32'd1);
        check("full_clr_full",  {31'd0, full_o},     32'd0);

        // Clear during WRITE aborts the pending word
        send(4'b0010, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0);
        do_clear();
        check("cw_count", {27'd0, count_o},    32'd0);
        check("cw_ready", {31'd0, in_ready_o}, 32'd1);
`ifdef PROG_NOP_FILL_EN
        read_check("cw_nop", 4'd0, 32'h00000013);
`else
        read_check("cw_nowrite", 4'd0, 32'h00000033);
`endif

        // Reset during WRITE after three words
        for (int i = 0; i < 3; i++) begin
            send(4'b0001, 1'b0, 5'd9, 5'd2, 5'd3, 12'd0);
            step();
        end
        check("rw_count3", {27'd0, count_o}, 32'd3);
        send(4'b0000, 1'b0, 5'd9, 5'd2, 5'd3, 12'd0);
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        check("rw_count", {27'd0, count_o},    32'd0);
        check("rw_ready", {31'd0, in_ready_o}, 32'd1);
        check("rw_full",  {31'd0, full_o},     32'd0);
`ifdef PROG_NOP_FILL_EN
        for (int a = 0; a < 16; a++) begin
            read_check("rw_nop", 4'(a), 32'h00000013);
        end
`else
        read_check("rw_word0",   4'd0, 32'h003164B3);
        read_check("rw_nowrite", 4'd3, 32'h000001B3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
